// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the Nibbler fetch sequencer and its environment:
// program ROM port, decode handshake, jump redirect, halt and debug read port.
// The master side is the sequencer; the slave side is ROM/decode/execute/debug.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 12
);

  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;

  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr_opcode;
  logic [7:0]        instr_operand;
  logic              instr_len2;
  logic [ADDR_W-1:0] instr_pc;

  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_addr;
  logic              halt;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic [7:0]        dbg_data;

  modport master (
    output rom_addr,
    input  rom_data,
    output instr_valid,
    input  instr_ready,
    output instr_opcode,
    output instr_operand,
    output instr_len2,
    output instr_pc,
    input  jmp_en,
    input  jmp_addr,
    input  halt,
    input  dbg_req,
    input  dbg_addr,
    output dbg_gnt,
    output dbg_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr_valid,
    output instr_ready,
    input  instr_opcode,
    input  instr_operand,
    input  instr_len2,
    input  instr_pc,
    output jmp_en,
    output jmp_addr,
    output halt,
    output dbg_req,
    output dbg_addr,
    input  dbg_gnt,
    input  dbg_data
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Nibbler fetch sequencer: owns the program counter, reads the combinational
// program ROM one byte per cycle, assembles 1- and 2-byte instructions for
// decode, applies jump redirects at the decode handshake, and lends the ROM
// bus to a debug reader only between instructions.
module fetch_sequencer #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH1,
    S_FETCH2,
    S_VALID,
    S_IDLE,
    S_DBG
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  state_t            r_state;
  state_t            w_nextState;

  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_opcode;
  logic [7:0]        r_operand;
  logic              r_len2;
  logic [ADDR_W-1:0] r_instrPc;
  logic [7:0]        r_dbgData;

  logic              w_isLen2;
  logic              w_handshake;
  logic              w_instrValid;
  logic              w_dbgGnt;
  logic [ADDR_W-1:0] w_romAddr;

  // Jump-class opcodes (top two bits zero) carry a second operand byte.
  assign w_isLen2    = (bus.rom_data[7:6] == 2'b00);
  assign w_handshake = (r_state == S_VALID) && bus.instr_ready;

  // State register; reset aborts any fetch or debug session immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH1;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the state-derived outputs (valid, grant, bus mux).
  always_comb begin
    w_nextState  = r_state;
    w_instrValid = 1'b0;
    w_dbgGnt     = 1'b0;
    w_romAddr    = r_pc;
    case (r_state)
      S_FETCH1: begin
        w_nextState = w_isLen2 ? S_FETCH2 : S_VALID;
      end
      S_FETCH2: begin
        w_nextState = S_VALID;
      end
      S_VALID: begin
        w_instrValid = 1'b1;
        if (bus.instr_ready) begin
          if (bus.dbg_req) begin
            w_nextState = S_DBG;
          end else if (bus.halt) begin
            w_nextState = S_IDLE;
          end else begin
            w_nextState = S_FETCH1;
          end
        end
      end
      S_IDLE: begin
        if (bus.dbg_req) begin
          w_nextState = S_DBG;
        end else if (!bus.halt) begin
          w_nextState = S_FETCH1;
        end
      end
      S_DBG: begin
        w_dbgGnt  = 1'b1;
        w_romAddr = bus.dbg_addr;
        if (!bus.dbg_req) begin
          w_nextState = S_FETCH1;
        end
      end
      default: begin
        w_nextState = S_FETCH1;
      end
    endcase
  end

  // Datapath: PC, instruction holding registers and the debug read-back byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_VEC;
      r_opcode  <= '0;
      r_operand <= '0;
      r_len2    <= 1'b0;
      r_instrPc <= '0;
      r_dbgData <= '0;
    end else begin
      case (r_state)
        S_FETCH1: begin
          r_opcode  <= bus.rom_data;
          r_instrPc <= r_pc;
          r_pc      <= r_pc + PC_STEP;
          if (!w_isLen2) begin
            r_operand <= '0;
            r_len2    <= 1'b0;
          end
        end
        S_FETCH2: begin
          r_operand <= bus.rom_data;
          r_len2    <= 1'b1;
          r_pc      <= r_pc + PC_STEP;
        end
        S_VALID: begin
          if (w_handshake && bus.jmp_en) begin
            r_pc <= bus.jmp_addr;
          end
        end
        S_DBG: begin
          r_dbgData <= bus.rom_data;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rom_addr      = w_romAddr;
  assign bus.instr_valid   = w_instrValid;
  assign bus.instr_opcode  = r_opcode;
  assign bus.instr_operand = r_operand;
  assign bus.instr_len2    = r_len2;
  assign bus.instr_pc      = r_instrPc;
  assign bus.dbg_gnt       = w_dbgGnt;
  assign bus.dbg_data      = r_dbgData;

endmodule
